// File: rtl/veririsc_core.sv
// veririsc_core
//   8-opcode accumulator CPU (VeriRISC ISA) driven by an explicit FSM.
//   Instructions and data share one external memory reached through a
//   variable-latency req/ack port, so wait-state memories can be attached.
//
// Parameters
//   DATA_WIDTH : word width of AC, instructions and memory data (>= ADDR_WIDTH+3)
//   ADDR_WIDTH : memory address width, PC and operand-address width
//   RESET_PC   : PC value after reset
//
// Ports
//   clk        : system clock, all state updates on the rising edge
//   rst        : synchronous reset, active low
//   mem_req    : memory access request
//   mem_we     : 1 = write, 0 = read (valid while mem_req=1)
//   mem_addr   : access address
//   mem_wdata  : write data (the accumulator)
//   mem_rdata  : read data, taken on the edge where mem_ack=1
//   mem_ack    : access completes on a rising edge with mem_req=1 and mem_ack=1
//   halt       : core halted
//   pc_out     : current PC
//   ac_out     : current accumulator
//   instr_cnt  : retired-instruction counter, saturating (only with VERIRISC_PERF_EN)
//
// Build option
//   VERIRISC_PERF_EN : adds the instr_cnt output and its counter.
//
// Instruction word: opcode = [DATA_WIDTH-1 -: 3], operand = [ADDR_WIDTH-1:0],
// remaining bits ignored.
//
// state  | meaning
// -------+-----------------------------------------------------------
// FETCH  | read instruction at PC; on ack latch IR, PC+1
// EXEC   | one-cycle decode; HLT/SKZ/JMP resolve here
// LOAD   | read operand for ADD/AND/XOR/LDA; AC updates on ack
// STORE  | write AC to operand address; done on ack
// HALTED | halt=1, no requests; left only through reset

module veririsc_core #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  halt,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [DATA_WIDTH-1:0] ac_out
`ifdef VERIRISC_PERF_EN
  ,
  output logic [15:0]           instr_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC,
    S_LOAD,
    S_STORE,
    S_HALTED
  } state_t;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  // Only the opcode and operand fields of IR are kept; the bits between
  // them never influence execution.
  opcode_t                 ir_op_q, ir_op_d;
  logic [ADDR_WIDTH-1:0]   ir_addr_q, ir_addr_d;
  logic [DATA_WIDTH-1:0]   ac_q, ac_d;
  logic                    retire;

  logic [ADDR_WIDTH-1:0]   pc_inc;
  assign pc_inc = pc_q + ADDR_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_op_q   <= OP_HLT;
      ir_addr_q <= '0;
      ac_q      <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_op_q   <= ir_op_d;
      ir_addr_q <= ir_addr_d;
      ac_q      <= ac_d;
    end
  end

  // Memory-port outputs depend only on state and registers; mem_ack and
  // mem_rdata only steer the next-state values.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_op_d   = ir_op_q;
    ir_addr_d = ir_addr_q;
    ac_d      = ac_q;
    retire    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc_q;
    halt      = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ack) begin
          ir_op_d   = opcode_t'(mem_rdata[DATA_WIDTH-1 -: 3]);
          ir_addr_d = mem_rdata[ADDR_WIDTH-1:0];
          pc_d      = pc_inc;
          state_d   = S_EXEC;
        end
      end

      S_EXEC: begin
        case (ir_op_q)
          OP_HLT: begin
            state_d = S_HALTED;
            retire  = 1'b1;
          end
          OP_SKZ: begin
            if (ac_q == '0) pc_d = pc_inc;
            state_d = S_FETCH;
            retire  = 1'b1;
          end
          OP_JMP: begin
            pc_d    = ir_addr_q;
            state_d = S_FETCH;
            retire  = 1'b1;
          end
          OP_STO: state_d = S_STORE;
          OP_ADD, OP_AND, OP_XOR, OP_LDA: state_d = S_LOAD;
          default: state_d = S_HALTED;
        endcase
      end

      S_LOAD: begin
        mem_req  = 1'b1;
        mem_addr = ir_addr_q;
        if (mem_ack) begin
          case (ir_op_q)
            OP_ADD:  ac_d = ac_q + mem_rdata;
            OP_AND:  ac_d = ac_q & mem_rdata;
            OP_XOR:  ac_d = ac_q ^ mem_rdata;
            OP_LDA:  ac_d = mem_rdata;
            default: ac_d = ac_q;
          endcase
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end

      S_STORE: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = ir_addr_q;
        if (mem_ack) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end

      S_HALTED: begin
        halt = 1'b1;
      end

      default: state_d = S_FETCH;
    endcase
  end

  assign mem_wdata = ac_q;
  assign pc_out    = pc_q;
  assign ac_out    = ac_q;

`ifdef VERIRISC_PERF_EN
  logic [15:0] instr_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      instr_cnt_q <= '0;
    end else if (retire && (instr_cnt_q != 16'hFFFF)) begin
      instr_cnt_q <= instr_cnt_q + 16'd1;
    end
  end

  assign instr_cnt = instr_cnt_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_veririsc_core.sv
module tb_veririsc_core;

  localparam int DW = 8;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          halt;
  logic [AW-1:0] pc_out;
  logic [DW-1:0] ac_out;
`ifdef VERIRISC_PERF_EN
  logic [15:0]   instr_cnt;
`endif

  veririsc_core #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_PC('0)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .halt      (halt),
    .pc_out    (pc_out),
`ifdef VERIRISC_PERF_EN
    .instr_cnt (instr_cnt),
`endif
    .ac_out    (ac_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_t;

  acc_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [DW-1:0] mem [0:31];
  int          wait_n = 0;
  bit          late_ack = 1'b0;
  int          wcnt = 0;
  bit          pend = 1'b0;
  logic [AW-1:0] p_addr;
  logic          p_we;
  logic [DW-1:0] p_wdata;
  logic [DW-1:0] p_ac;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    acc_t e;
    e.we = we; e.addr = addr; e.wdata = wdata;
    exp_q.push_back(e);
  endtask

  // Memory model and monitor: decides ack half a cycle before the edge,
  // so an ack decided here completes on the following rising edge.
  always @(negedge clk) begin
    acc_t e;
    #1;
    if (!rst) begin
      mem_ack   = late_ack;
      mem_rdata = 8'hFF;
      wcnt      = 0;
      pend      = 1'b0;
    end else begin
      if (pend) begin
        chk("wait_req_held", {31'd0, mem_req}, 32'd1);
        chk("wait_addr_stable", {27'd0, mem_addr}, {27'd0, p_addr});
        chk("wait_we_stable", {31'd0, mem_we}, {31'd0, p_we});
        chk("wait_wdata_stable", {24'd0, mem_wdata}, {24'd0, p_wdata});
        chk("wait_ac_stable", {24'd0, ac_out}, {24'd0, p_ac});
      end
      if (mem_req) begin
        if (wcnt >= wait_n) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr];
          wcnt      = 0;
          pend      = 1'b0;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_access: got addr %0h we %0b, expected no access", mem_addr, mem_we);
          end else begin
            e = exp_q.pop_front();
            chk("access_addr", {27'd0, mem_addr}, {27'd0, e.addr});
            chk("access_we", {31'd0, mem_we}, {31'd0, e.we});
            if (e.we) chk("access_wdata", {24'd0, mem_wdata}, {24'd0, e.wdata});
          end
          if (mem_we) mem[mem_addr] = mem_wdata;
        end else begin
          mem_ack = 1'b0;
          wcnt++;
          pend    = 1'b1;
          p_addr  = mem_addr;
          p_we    = mem_we;
          p_wdata = mem_wdata;
          p_ac    = ac_out;
        end
      end else begin
        mem_ack = 1'b0;
        wcnt    = 0;
        pend    = 1'b0;
      end
    end
  end

  task automatic prep(input int waits);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    exp_q.delete();
    wait_n = waits;
  endtask

  // Releases reset and counts cycles until halt, then checks the core
  // stays frozen for a few more cycles.
  task automatic run_to_halt(input string tag, input int exp_cyc,
                             input logic [AW-1:0] exp_pc, input logic [DW-1:0] exp_ac);
    int cyc;
    cyc = 0;
    @(negedge clk);
    rst = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
    end while (!halt && cyc < 400);
    chk({tag, "_halt_cycles"}, cyc, exp_cyc);
    chk({tag, "_pc"}, {27'd0, pc_out}, {27'd0, exp_pc});
    chk({tag, "_ac"}, {24'd0, ac_out}, {24'd0, exp_ac});
    chk({tag, "_queue_left"}, exp_q.size(), 0);
    repeat (3) @(negedge clk);
    chk({tag, "_halt_held"}, {31'd0, halt}, 32'd1);
    chk({tag, "_halt_no_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_halt_pc_held"}, {27'd0, pc_out}, {27'd0, exp_pc});
    chk({tag, "_halt_ac_held"}, {24'd0, ac_out}, {24'd0, exp_ac});
  endtask

  task automatic load_prog1();
    mem[0]  = 8'hAA;  // LDA 10
    mem[1]  = 8'h4B;  // ADD 11
    mem[2]  = 8'hCC;  // STO 12
    mem[3]  = 8'h00;  // HLT
    mem[10] = 8'h05;
    mem[11] = 8'h03;
    push(1'b0, 5'd0, 8'h00);
    push(1'b0, 5'd10, 8'h00);
    push(1'b0, 5'd1, 8'h00);
    push(1'b0, 5'd11, 8'h00);
    push(1'b0, 5'd2, 8'h00);
    push(1'b1, 5'd12, 8'h08);
    push(1'b0, 5'd3, 8'h00);
  endtask

  initial begin
    int cyc;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_halt", {31'd0, halt}, 32'd0);
    chk("rst_pc", {27'd0, pc_out}, 32'd0);
    chk("rst_ac", {24'd0, ac_out}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd1);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", {27'd0, mem_addr}, 32'd0);
`ifdef VERIRISC_PERF_EN
    chk("rst_instr_cnt", {16'd0, instr_cnt}, 32'd0);
`endif

    // LDA/ADD/STO/HLT, zero wait: 3+3+3+2 cycles
    prep(0);
    load_prog1();
    run_to_halt("t1", 11, 5'd4, 8'h08);
    chk("t1_mem12", {24'd0, mem[12]}, 32'h08);
`ifdef VERIRISC_PERF_EN
    chk("t1_instr_cnt", {16'd0, instr_cnt}, 32'd4);
`endif

    // SKZ with AC=0 skips mem[1]; JMP 5; HLT -> 2+2+2 cycles
    prep(0);
    mem[0] = 8'h20; mem[1] = 8'h00; mem[2] = 8'hE5; mem[5] = 8'h00;
    push(1'b0, 5'd0, 8'h00);
    push(1'b0, 5'd2, 8'h00);
    push(1'b0, 5'd5, 8'h00);
    run_to_halt("t2a", 6, 5'd6, 8'h00);

    // LDA 10 (=1) then SKZ does not skip; HLT at 2 -> 3+2+2 cycles
    prep(0);
    mem[0] = 8'hAA; mem[1] = 8'h20; mem[2] = 8'h00; mem[10] = 8'h01;
    push(1'b0, 5'd0, 8'h00);
    push(1'b0, 5'd10, 8'h00);
    push(1'b0, 5'd1, 8'h00);
    push(1'b0, 5'd2, 8'h00);
    run_to_halt("t2b", 7, 5'd3, 8'h01);

    // Three wait cycles on each of the 7 accesses: 11 + 7*3 cycles
    prep(3);
    load_prog1();
    run_to_halt("t3", 32, 5'd4, 8'h08);
    chk("t3_mem12", {24'd0, mem[12]}, 32'h08);

    // JMP 31; SKZ at 31 wraps PC to 0 then skips to 1; HLT at 1
    prep(0);
    mem[0] = 8'hFF; mem[31] = 8'h20; mem[1] = 8'h00;
    push(1'b0, 5'd0, 8'h00);
    push(1'b0, 5'd31, 8'h00);
    push(1'b0, 5'd1, 8'h00);
    run_to_halt("t4", 6, 5'd2, 8'h00);

    // Reset while ADD waits for its operand
    prep(2);
    mem[0] = 8'hAA; mem[1] = 8'h4B; mem[10] = 8'h05; mem[11] = 8'h03;
    push(1'b0, 5'd0, 8'h00);
    push(1'b0, 5'd10, 8'h00);
    push(1'b0, 5'd1, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(mem_req && !mem_we && mem_addr == 5'd11) && cyc < 100);
    chk("t5_reached_load", {31'd0, (cyc < 100)}, 32'd1);
    chk("t5_pre_ac", {24'd0, ac_out}, 32'h05);
    chk("t5_pre_pc", {27'd0, pc_out}, 32'd2);
    late_ack = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_ac", {24'd0, ac_out}, 32'd0);
    chk("t5_rst_pc", {27'd0, pc_out}, 32'd0);
    chk("t5_rst_req", {31'd0, mem_req}, 32'd1);
    chk("t5_rst_we", {31'd0, mem_we}, 32'd0);
    chk("t5_rst_addr", {27'd0, mem_addr}, 32'd0);
    @(negedge clk);
    chk("t5_late_ack_ac", {24'd0, ac_out}, 32'd0);
    chk("t5_late_ack_pc", {27'd0, pc_out}, 32'd0);
    chk("t5_late_ack_halt", {31'd0, halt}, 32'd0);
    late_ack = 1'b0;
    chk("t5_queue_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
